uart_axil_responder: RTL and testbench

AXI4-Lite responder for the chipset UART register window, on the 13-bit-address, 32-bit-data uart_axi_* interface. Decodes a 16550-subset register map (data, interrupt enable, interrupt ID, line status, scratch). Buffers transmit and receive bytes in two synchronous FIFOs exposed as byte valid/ready streams toward the serializer. Drives uart_irq.

---
 rtl/uart_axil_pkg.sv | 40 ++++
 rtl/uart_axil_fifo.sv | 62 ++++++
 rtl/uart_axil_responder.sv | 216 +++++++++++++++++++++
 tb/tb_uart_axil_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axil_pkg.sv
// ============================================================================
// uart_axil_pkg: register map, LSR/IIR encodings and AXI response codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_axil_pkg;

  localparam logic [2:0] OFF_RBR_THR = 3'd0;
  localparam logic [2:0] OFF_IER     = 3'd1;
  localparam logic [2:0] OFF_IIR     = 3'd2;
  localparam logic [2:0] OFF_LSR     = 3'd5;
  localparam logic [2:0] OFF_SCR     = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam logic [7:0] IIR_RX_AVAIL = 8'hC4;
  localparam logic [7:0] IIR_THR_EMPTY = 8'hC2;
  localparam logic [7:0] IIR_NONE     = 8'hC1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Receive-data interrupt outranks transmitter-empty.
  function automatic logic [7:0] iir_code(input logic [1:0] ier, input logic dr,
                                          input logic thre);
    if (ier[0] && dr)
      return IIR_RX_AVAIL;
    else if (ier[1] && thre)
      return IIR_THR_EMPTY;
    else
      return IIR_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_axil_fifo.sv
// ============================================================================
// uart_axil_fifo: synchronous FIFO, full/empty derived from a registered count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_axil_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_axil_responder.sv
// ============================================================================
// uart_axil_responder: AXI4-Lite 16550-subset UART register window with byte FIFOs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_axil_responder
  import uart_axil_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst,
  input  logic [ADDR_W-1:0]     uart_axi_awaddr,
  input  logic                  uart_axi_awvalid,
  output logic                  uart_axi_awready,
  input  logic [DATA_W-1:0]     uart_axi_wdata,
  input  logic [DATA_W/8-1:0]   uart_axi_wstrb,
  input  logic                  uart_axi_wvalid,
  output logic                  uart_axi_wready,
  output logic [1:0]            uart_axi_bresp,
  output logic                  uart_axi_bvalid,
  input  logic                  uart_axi_bready,
  input  logic [ADDR_W-1:0]     uart_axi_araddr,
  input  logic                  uart_axi_arvalid,
  output logic                  uart_axi_arready,
  output logic [DATA_W-1:0]     uart_axi_rdata,
  output logic [1:0]            uart_axi_rresp,
  output logic                  uart_axi_rvalid,
  input  logic                  uart_axi_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  uart_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              clk;
  logic              rst;
  assign clk = chipset_clk;
  assign rst = chipset_rst;

  logic              aw_held, w_held, bvalid_q;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        w_byte;
  logic              w_strb0;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [1:0]        ier;
  logic [7:0]        scr;
  logic              oe;
  logic              irq_q;

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]        rx_dout;
  logic [CNT_W-1:0]  tx_count, rx_count;

  logic aw_hs, w_hs, b_hs, commit, wr_err, wr_en, thr_write, oe_set;
  logic ar_hs, rd_err, rbr_pop, lsr_read, rx_push, dr, thre;
  logic [2:0] wr_off, rd_off;
  logic [7:0] lsr, rd_byte;

  assign aw_hs     = uart_axi_awvalid && !aw_held;
  assign w_hs      = uart_axi_wvalid && !w_held;
  assign b_hs      = bvalid_q && uart_axi_bready;
  assign commit    = aw_held && w_held && !bvalid_q;
  assign wr_err    = |aw_addr[ADDR_W-1:5];
  assign wr_off    = aw_addr[4:2];
  assign wr_en     = commit && !wr_err && w_strb0;
  assign thr_write = wr_en && (wr_off == OFF_RBR_THR);
  assign oe_set    = thr_write && tx_full;

  assign ar_hs     = uart_axi_arvalid && !rvalid_q;
  assign rd_err    = |uart_axi_araddr[ADDR_W-1:5];
  assign rd_off    = uart_axi_araddr[4:2];
  assign rbr_pop   = ar_hs && !rd_err && (rd_off == OFF_RBR_THR) && !rx_empty;
  assign lsr_read  = ar_hs && !rd_err && (rd_off == OFF_LSR);
  assign rx_push   = rx_valid && !rx_full;
  assign dr        = !rx_empty;
  assign thre      = tx_empty;

  assign uart_axi_awready = !aw_held;
  assign uart_axi_wready  = !w_held;
  assign uart_axi_bvalid  = bvalid_q;
  assign uart_axi_bresp   = bresp_q;
  assign uart_axi_arready = !rvalid_q;
  assign uart_axi_rvalid  = rvalid_q;
  assign uart_axi_rdata   = rdata_q;
  assign uart_axi_rresp   = rresp_q;
  assign tx_valid         = !tx_empty;
  assign rx_ready         = !rx_full;
  assign uart_irq         = irq_q;

  always_comb begin
    lsr           = 8'h00;
    lsr[LSR_DR]   = dr;
    lsr[LSR_OE]   = oe;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = tx_empty;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (!rd_err) begin
      case (rd_off)
        OFF_RBR_THR: rd_byte = rx_empty ? 8'h00 : rx_dout;
        OFF_IER:     rd_byte = {6'b0, ier};
        OFF_IIR:     rd_byte = iir_code(ier, dr, thre);
        OFF_LSR:     rd_byte = lsr;
        OFF_SCR:     rd_byte = scr;
        default:     rd_byte = 8'h00;
      endcase
    end
  end

  // Write channel: AW and W latch independently and stay blocked until B completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      aw_addr  <= '0;
      w_byte   <= 8'h00;
      w_strb0  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= uart_axi_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        w_byte  <= uart_axi_wdata[7:0];
        w_strb0 <= uart_axi_wstrb[0];
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (b_hs) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= {{(DATA_W-8){1'b0}}, rd_byte};
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && uart_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ier   <= 2'b00;
      scr   <= 8'h00;
      oe    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && (wr_off == OFF_IER)) ier <= w_byte[1:0];
      if (wr_en && (wr_off == OFF_SCR)) scr <= w_byte;
      // An overrun arriving in the same cycle as the LSR read must not be lost.
      if (oe_set)        oe <= 1'b1;
      else if (lsr_read) oe <= 1'b0;
      irq_q <= (ier[0] && dr) || (ier[1] && thre);
    end
  end

  uart_axil_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (thr_write),
    .pop   (tx_ready),
    .din   (w_byte),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_axil_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rbr_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  logic unused_bits;
  assign unused_bits = ^{uart_axi_wdata[DATA_W-1:8], uart_axi_wstrb[DATA_W/8-1:1],
                         aw_addr[1:0], uart_axi_araddr[1:0], tx_count, rx_count};

endmodule

`default_nettype wire

// File: tb/tb_uart_axil_responder.sv
// ============================================================================
// tb_uart_axil_responder: directed and random checks against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_axil_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  always #5 clk = ~clk;

  uart_axil_responder #(.FIFO_DEPTH(DEPTH), .ADDR_W(13), .DATA_W(32)) dut (
    .chipset_clk      (clk),
    .chipset_rst      (rst),
    .uart_axi_awaddr  (awaddr),
    .uart_axi_awvalid (awvalid),
    .uart_axi_awready (awready),
    .uart_axi_wdata   (wdata),
    .uart_axi_wstrb   (wstrb),
    .uart_axi_wvalid  (wvalid),
    .uart_axi_wready  (wready),
    .uart_axi_bresp   (bresp),
    .uart_axi_bvalid  (bvalid),
    .uart_axi_bready  (bready),
    .uart_axi_araddr  (araddr),
    .uart_axi_arvalid (arvalid),
    .uart_axi_arready (arready),
    .uart_axi_rdata   (rdata),
    .uart_axi_rresp   (rresp),
    .uart_axi_rvalid  (rvalid),
    .uart_axi_rready  (rready),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .uart_irq         (irq)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  logic [1:0]   m_ier;
  logic [7:0]   m_scr;
  bit           m_oe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_lsr();
    logic te;
    te = (tx_q.size() == 0);
    return {1'b0, te, te, 3'b000, m_oe, rx_q.size() != 0};
  endfunction

  function automatic logic [7:0] m_iir();
    if (m_ier[0] && rx_q.size() != 0) return 8'hC4;
    if (m_ier[1] && tx_q.size() == 0) return 8'hC2;
    return 8'hC1;
  endfunction

  function automatic logic m_irq();
    return (m_ier[0] && rx_q.size() != 0) || (m_ier[1] && tx_q.size() == 0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    tx_ready = 0; rx_valid = 0; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; rx_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tx_q.delete(); rx_q.delete(); m_ier = 0; m_scr = 0; m_oe = 0;
  endtask

  task automatic axi_write(input logic [12:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic [1:0] exp_resp;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
      if (cyc > 100) begin chk("wr_accept_timeout", 0, 1); break; end
    end
    awvalid = 0; wvalid = 0;
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("bvalid_seen", bvalid, 1);
    if (addr[12:5] != 0) exp_resp = 2'b10;
    else begin
      exp_resp = 2'b00;
      if (strb[0]) begin
        case (addr[4:2])
          3'd0: if (tx_q.size() < DEPTH) tx_q.push_back(data[7:0]); else m_oe = 1;
          3'd1: m_ier = data[1:0];
          3'd7: m_scr = data[7:0];
          default: ;
        endcase
      end
    end
    chk("bresp", bresp, exp_resp);
    // A second address offered while B is pending must be held off.
    awaddr = 13'h001C;
    repeat (b_dly) begin
      awvalid = 1;
      @(posedge clk); #1;
      chk("bvalid_hold", bvalid, 1);
      chk("awready_blocked", awready, 0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0; awvalid = 0;
    chk("awready_after_b", awready, 1);
  endtask

  task automatic axi_read(input logic [12:0] addr, input int r_dly, output logic [31:0] data);
    int cyc = 0;
    logic [7:0] exp;
    logic [1:0] exp_resp;
    exp = 0; exp_resp = 0;
    if (addr[12:5] != 0) exp_resp = 2'b10;
    else begin
      case (addr[4:2])
        3'd0: if (rx_q.size() != 0) exp = rx_q.pop_front();
        3'd1: exp = {6'b0, m_ier};
        3'd2: exp = m_iir();
        3'd5: begin exp = m_lsr(); m_oe = 0; end
        3'd7: exp = m_scr;
        default: exp = 0;
      endcase
    end
    araddr = addr; arvalid = 1;
    while (!arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("arready_seen", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("arready_busy", arready, 0);
    chk("rdata", rdata, {24'h0, exp});
    chk("rresp", rresp, exp_resp);
    repeat (r_dly) begin
      @(posedge clk); #1;
      chk("rdata_hold", rdata, {24'h0, exp});
    end
    data = rdata;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("arready_after_r", arready, 1);
  endtask

  task automatic tx_pop();
    chk("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    tx_ready = 1;
    @(posedge clk); #1;
    tx_ready = 0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic rx_push(input logic [7:0] b);
    chk("rx_ready", rx_ready, rx_q.size() < DEPTH);
    rx_data = b; rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
  endtask

  task automatic check_irq(input string tag);
    @(posedge clk); #1;
    chk(tag, irq, m_irq());
  endtask

  logic [31:0] rd;

  initial begin
    do_reset();
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_irq", irq, 0);

    axi_write(13'h0000, 32'h41, 4'h1, 0, 0, 0);
    chk("thr_tx_valid", tx_valid, 1);
    chk("thr_tx_data", tx_data, 8'h41);
    axi_read(13'h0014, 0, rd);
    chk("lsr_after_thr", rd, 32'h0);
    tx_pop();

    axi_write(13'h001C, 32'h5A, 4'h1, 3, 0, 5);
    axi_read(13'h001C, 2, rd);
    chk("scr_after_split", rd, 32'h5A);

    for (int i = 0; i < DEPTH + 1; i++) axi_write(13'h0000, 32'h80 + i, 4'h1, 0, 0, 0);
    axi_read(13'h0014, 0, rd);
    chk("lsr_overrun", rd, 32'h02);
    axi_read(13'h0014, 0, rd);
    chk("lsr_oe_cleared", rd, 32'h00);
    for (int i = 0; i < DEPTH; i++) tx_pop();
    axi_read(13'h0014, 0, rd);
    chk("lsr_drained", rd, 32'h60);

    axi_write(13'h0004, 32'h1, 4'h1, 0, 0, 0);
    rx_push(8'h10);
    rx_push(8'h11);
    check_irq("irq_rx");
    chk("irq_rx_level", irq, 1);
    axi_read(13'h0008, 0, rd);
    chk("iir_rx", rd, 32'hC4);
    axi_read(13'h0000, 0, rd);
    chk("rbr0", rd, 32'h10);
    axi_read(13'h0000, 0, rd);
    chk("rbr1", rd, 32'h11);
    axi_read(13'h0000, 0, rd);
    chk("rbr_empty", rd, 32'h00);
    check_irq("irq_rx_clear");
    chk("irq_rx_clear_level", irq, 0);

    axi_read(13'h0020, 0, rd);
    chk("slverr_rdata", rd, 32'h0);
    axi_write(13'h1000, 32'hFF, 4'h1, 0, 0, 0);
    axi_write(13'h101C, 32'h33, 4'h1, 0, 0, 0);
    chk("slverr_no_tx", tx_valid, 0);
    axi_read(13'h001C, 0, rd);
    chk("slverr_scr_kept", rd, 32'h5A);

    axi_write(13'h001C, 32'hA5, 4'h1, 0, 0, 0);
    axi_read(13'h001C, 0, rd);
    chk("scr_a5", rd, 32'hA5);
    axi_write(13'h001C, 32'h77, 4'h0, 0, 0, 0);
    axi_read(13'h001C, 0, rd);
    chk("scr_nostrb", rd, 32'hA5);
    axi_write(13'h0004, 32'h2, 4'h1, 0, 0, 0);
    check_irq("irq_thre");
    chk("irq_thre_level", irq, 1);
    axi_read(13'h0008, 0, rd);
    chk("iir_thre", rd, 32'hC2);

    // Reset with a write address pending and data in both FIFOs.
    axi_write(13'h0000, 32'h99, 4'h1, 0, 0, 0);
    rx_push(8'h55);
    awaddr = 13'h001C; awvalid = 1;
    @(posedge clk); #1;
    chk("mid_awready_low", awready, 0);
    do_reset();
    chk("mid_rst_awready", awready, 1);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    axi_read(13'h0000, 0, rd);
    chk("mid_rst_rbr", rd, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [12:0] a;
      a = {8'h00, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a[12:5] = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 5))
        0, 1: axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 2));
        2:    axi_read(a, $urandom_range(0, 2), rd);
        3:    rx_push(8'($urandom));
        4:    tx_pop();
        default: check_irq("irq_rand");
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
